// File: rtl/pulse_train_sequencer.sv
// ============================================================================
// pulse_train_sequencer: bounded, start/done-handshaked programmable pulse train.
// Optional abort support is enabled by defining PULSE_ABORT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pulse_train_sequencer #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
`ifdef PULSE_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hl_q;
  logic [CNT_W-1:0] ll_q;
  logic [NUM_W-1:0] np_q;
  logic             abort_req;

`ifdef PULSE_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // cnt holds the cycles remaining in the current phase after this one
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hl_q      <= '0;
      ll_q      <= '0;
      np_q      <= '0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
`ifdef PULSE_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            hl_q      <= high_len;
            ll_q      <= low_len;
            np_q      <= num_pulses;
            pulse_idx <= '0;
            if (num_pulses == '0 || high_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_HIGH;
              pulse <= 1'b1;
              busy  <= 1'b1;
              cnt   <= high_len - CNT_ONE;
            end
          end
        end
        S_HIGH: begin
          if (abort_req) begin
            state <= S_DONE;
            pulse <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef PULSE_ABORT_EN
            aborted <= 1'b1;
`endif
          end else if (cnt == '0) begin
            pulse <= 1'b0;
            if (pulse_idx == np_q - NUM_ONE) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_LOW;
              // a zero low length still yields one low cycle between pulses
              cnt   <= (ll_q == '0) ? '0 : ll_q - CNT_ONE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_LOW: begin
          if (abort_req) begin
            state <= S_DONE;
            pulse <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef PULSE_ABORT_EN
            aborted <= 1'b1;
`endif
          end else if (cnt == '0) begin
            state     <= S_HIGH;
            pulse     <= 1'b1;
            pulse_idx <= pulse_idx + NUM_ONE;
            cnt       <= hl_q - CNT_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
`ifdef PULSE_ABORT_EN
          aborted <= 1'b0;
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_sequencer.sv
// ============================================================================
// tb_pulse_train_sequencer: directed + random checks against a timeline model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_train_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] num_pulses;
  logic       pulse;
  logic       busy;
  logic       done;
  logic [7:0] pulse_idx;
`ifdef PULSE_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  pulse_train_sequencer #(.CNT_W(8), .NUM_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
`ifdef PULSE_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pulse;
    logic       busy;
    logic       done;
    logic       ab;
    logic [7:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt;
  int   done_cnt;

  // Expected per-cycle outputs of one accepted train, from the timing rules
  function automatic void push_train(int h, int l, int n);
    exp_t e;
    if (n == 0 || h == 0) begin
      e = '0; e.done = 1'b1;
      q.push_back(e);
      return;
    end
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < h; c++) begin
        e = '0; e.pulse = 1'b1; e.busy = 1'b1; e.idx = 8'(p);
        q.push_back(e);
      end
      if (p < n - 1) begin
        for (int c = 0; c < ((l == 0) ? 1 : l); c++) begin
          e = '0; e.busy = 1'b1; e.idx = 8'(p);
          q.push_back(e);
        end
      end
    end
    e = '0; e.done = 1'b1; e.idx = 8'(n - 1);
    q.push_back(e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit rst);
    exp_t e;
    reset = rst;
    start = st;
`ifdef PULSE_ABORT_EN
    abort = ab;
`endif
    if (rst) begin
      q.delete();
    end else if (q.size() == 0 && !cur.done) begin
      if (st) push_train(int'(high_len), int'(low_len), int'(num_pulses));
    end else if (ab && cur.busy) begin
`ifdef PULSE_ABORT_EN
      q.delete();
      e = '0; e.done = 1'b1; e.ab = 1'b1; e.idx = cur.idx;
      q.push_back(e);
`endif
    end
    @(posedge clk);
    #1;
    if (rst) cur = '0;
    else if (q.size() != 0) cur = q.pop_front();
    else begin
      e = '0; e.idx = cur.idx;
      cur = e;
    end
    chk("pulse", 32'(pulse), 32'(cur.pulse));
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("done", 32'(done), 32'(cur.done));
    chk("pulse_idx", 32'(pulse_idx), 32'(cur.idx));
`ifdef PULSE_ABORT_EN
    chk("aborted", 32'(aborted), 32'(cur.ab));
`endif
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic cfg(input int h, input int l, input int n);
    high_len = 8'(h); low_len = 8'(l); num_pulses = 8'(n);
  endtask

  initial begin
    cur = '0;
    reset = 1'b1; start = 1'b0;
`ifdef PULSE_ABORT_EN
    abort = 1'b0;
`endif
    cfg(3, 2, 4);

    // reset dominates start
    step(1, 0, 1);
    step(1, 0, 1);
    step(0, 0, 0);

    // H=3 L=2 N=4: 18 busy cycles, one done strobe
    cfg(3, 2, 4);
    busy_cnt = 0; done_cnt = 0;
    step(1, 0, 0);
    cfg(7, 7, 7);
    for (int i = 0; i < 22; i++) step(0, 0, 0);
    chk("train_busy_cycles", 32'(busy_cnt), 32'd18);
    chk("train_done_count", 32'(done_cnt), 32'd1);

    // degenerate trains
    cfg(5, 2, 0);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    cfg(0, 2, 3);
    busy_cnt = 0;
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("degenerate_busy", 32'(busy_cnt), 32'd0);

    // start held high: back-to-back trains separated by DONE and one IDLE cycle
    cfg(1, 0, 3);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // reset on the 2nd high cycle of pulse 1
    cfg(4, 4, 5);
    done_cnt = 0;
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0);
    step(0, 0, 1);
    chk("reset_mid_idx", 32'(pulse_idx), 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("reset_mid_no_done", 32'(done_cnt), 32'd0);

`ifdef PULSE_ABORT_EN
    // abort in the LOW phase after pulse 1
    cfg(2, 3, 4);
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    step(0, 1, 0);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_idx", 32'(pulse_idx), 32'd1);
    step(0, 1, 0);
    step(0, 0, 0);
`endif

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4));
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
